bcd_serial_adder: RTL and testbench

//  Parametrised, digit-serial packed-BCD adder: generalises the fixed 8-digit ripple BCD adder to
//  NUM_DIGITS digits and processes one digit per clock, least significant digit first.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 148 ++++++++++++++
 tb/tb_bcd_serial_adder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the digit-serial BCD adder.
// Optional nines-complement subtract path is enabled by defining BCD_SUB_EN.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_DIGITS    = 8;
    localparam int DEF_IDX_W     = idx_width(DEF_DIGITS);

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction and out-of-range flag.
// Purely combinational; the top reuses one instance for every digit step.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout,
    output logic                   bad
);

    logic [BCD_DIGIT_W:0] t;
    logic [BCD_DIGIT_W:0] tc;

    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        tc   = t + (BCD_DIGIT_W+1)'(BCD_CORR);
        cout = t > (BCD_DIGIT_W+1)'(BCD_MAX);
        s    = cout ? tc[BCD_DIGIT_W-1:0] : t[BCD_DIGIT_W-1:0];
        bad  = (a > BCD_DIGIT_W'(BCD_MAX)) | (b > BCD_DIGIT_W'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first, with start/ack handshake.
// Define BCD_SUB_EN to enable A - B via nines complement of B when sub_i is set.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] a_i,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] b_i,
    input  logic                              cin_i,
    input  logic                              sub_i,
    input  logic                              ack_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] sum_o,
    output logic                              cout_o,
    output logic                              invalid_o
);

    localparam int W  = BCD_DIGIT_W * NUM_DIGITS;
    localparam int IW = idx_width(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          inv_q, inv_d;

    logic [BCD_DIGIT_W-1:0] a_dig, b_dig, s_dig;
    logic                   c_dig, bad_dig;

    assign a_dig = a_q[BCD_DIGIT_W-1:0];

`ifdef BCD_SUB_EN
    logic sub_q, sub_d;

    // 9-b maps raw 10..15 onto 15..10, so the bad flag still tracks raw b
    assign b_dig = sub_q
                 ? BCD_DIGIT_W'(BCD_DIGIT_W'(BCD_MAX) - b_q[BCD_DIGIT_W-1:0])
                 : b_q[BCD_DIGIT_W-1:0];

    always_comb begin
        sub_d = sub_q;
        if (ready_o && start_i) begin
            sub_d = sub_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`else
    logic unused_sub;

    assign unused_sub = sub_i;
    assign b_dig      = b_q[BCD_DIGIT_W-1:0];
`endif

    bcd_digit_add u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (s_dig),
        .cout (c_dig),
        .bad  (bad_dig)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sum_d   = '0;
                    idx_d   = '0;
                    carry_d = cin_i;
                    cout_d  = 1'b0;
                    inv_d   = 1'b0;
                end else if (state_q == ST_DONE && ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] = s_dig;
                carry_d = c_dig;
                inv_d   = inv_q | bad_dig;
                a_d     = a_q >> BCD_DIGIT_W;
                b_d     = b_q >> BCD_DIGIT_W;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    cout_d  = c_dig;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
        end
    end

    assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign valid_o   = (state_q == ST_DONE);
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign invalid_o = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised and directed bench for bcd_serial_adder (N=8 and N=1 instances).
// Reference model works on decimal values; out-of-range digits use the per-digit rule.
module tb_bcd_serial_adder;

    localparam int N = 8;

`ifdef BCD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cin, sub, ack;
    logic [31:0] a, b;
    logic        ready, valid, cout, inv;
    logic [31:0] sum;

    logic        s_start, s_cin, s_sub, s_ack;
    logic [3:0]  s_a, s_b, s_sum;
    logic        s_ready, s_valid, s_cout, s_inv;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.NUM_DIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .cin_i     (cin),
        .sub_i     (sub),
        .ack_i     (ack),
        .ready_o   (ready),
        .valid_o   (valid),
        .sum_o     (sum),
        .cout_o    (cout),
        .invalid_o (inv)
    );

    bcd_serial_adder #(.NUM_DIGITS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (s_start),
        .a_i       (s_a),
        .b_i       (s_b),
        .cin_i     (s_cin),
        .sub_i     (s_sub),
        .ack_i     (s_ack),
        .ready_o   (s_ready),
        .valid_o   (s_valid),
        .sum_o     (s_sum),
        .cout_o    (s_cout),
        .invalid_o (s_inv)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint dec(input logic [31:0] x);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(x[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] enc(input longint v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [31:0] ms, output logic mco,
                                  output logic minv);
        bit     sb = msub & SUB_EN;
        longint da, db, tot;
        int     c, t, bd;
        minv = 1'b0;
        for (int i = 0; i < 8; i++)
            if (ma[i*4 +: 4] > 9 || mb[i*4 +: 4] > 9) minv = 1'b1;
        if (!minv) begin
            da  = dec(ma);
            db  = sb ? (longint'(99999999) - dec(mb)) : dec(mb);
            tot = da + db + longint'(mcin);
            mco = tot >= 100000000;
            ms  = enc(tot % 100000000);
        end else begin
            c  = int'(mcin);
            ms = '0;
            for (int i = 0; i < 8; i++) begin
                bd = int'(mb[i*4 +: 4]);
                if (sb) bd = (9 - bd) & 15;
                t  = int'(ma[i*4 +: 4]) + bd + c;
                c  = (t > 9) ? 1 : 0;
                ms[i*4 +: 4] = 4'((t > 9) ? t + 6 : t);
            end
            mco = c[0];
        end
    endfunction

    task automatic launch(input logic [31:0] la, input logic [31:0] lb,
                          input logic lcin, input logic lsub, input logic lack);
        a     = la;
        b     = lb;
        cin   = lcin;
        sub   = lsub;
        start = 1'b1;
        ack   = lack;
        @(posedge clk);
        #1;
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic wait_check(input string tag, input logic [31:0] ea,
                              input logic [31:0] eb, input logic ecin,
                              input logic esub, input int done_edges);
        logic [31:0] es;
        logic        eco, einv;
        int          lat = done_edges;
        bit          seen = 1'b0;
        model(ea, eb, ecin, esub, es, eco, einv);
        while (lat < N + 4 && !seen) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) seen = 1'b1;
        end
        chk({tag, "_lat"}, lat, N);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, eco);
        chk({tag, "_inv"}, inv, einv);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ack_ready", ready, 1'b1);
        chk("ack_valid", valid, 1'b0);
    endtask

    function automatic logic [31:0] rnd_bcd(input bit allow_bad);
        logic [31:0] r;
        for (int i = 0; i < 8; i++)
            r[i*4 +: 4] = (allow_bad && $urandom_range(7) == 0)
                        ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
        return r;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        bit          saw;
        rst_n = 1'b0;
        {start, cin, sub, ack} = '0;
        a = '0;
        b = '0;
        {s_start, s_cin, s_sub, s_ack} = '0;
        s_a = '0;
        s_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_inv", inv, 1'b0);
        chk("rst1_ready", s_ready, 1'b1);
        rst_n = 1'b1;

        launch(32'h12345678, 32'h87654321, 1'b0, 1'b0, 1'b0);
        wait_check("t1", 32'h12345678, 32'h87654321, 1'b0, 1'b0, 0);
        chk("t1_lit_sum", sum, 32'h99999999);
        do_ack();

        launch(32'h99999999, 32'h00000001, 1'b0, 1'b0, 1'b0);
        wait_check("t2", 32'h99999999, 32'h00000001, 1'b0, 1'b0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t2_hold_valid", valid, 1'b1);
            chk("t2_hold_sum", sum, 32'h0);
            chk("t2_hold_cout", cout, 1'b1);
        end
        do_ack();

        launch(32'h0000000A, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_check("t3", 32'h0000000A, 32'h0, 1'b0, 1'b0, 0);
        chk("t3_inv_lit", inv, 1'b1);
        chk("t3_d0", sum[3:0], 4'h0);
        do_ack();
        launch(32'h00000015, 32'h00000027, 1'b0, 1'b0, 1'b0);
        wait_check("t3b", 32'h00000015, 32'h00000027, 1'b0, 1'b0, 0);
        chk("t3b_inv_clr", inv, 1'b0);
        do_ack();

`ifdef BCD_SUB_EN
        launch(32'h00000100, 32'h00000001, 1'b1, 1'b1, 1'b0);
        wait_check("t4a", 32'h00000100, 32'h00000001, 1'b1, 1'b1, 0);
        chk("t4a_lit", sum, 32'h00000099);
        do_ack();
        launch(32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b0);
        wait_check("t4b", 32'h00000001, 32'h00000002, 1'b1, 1'b1, 0);
        chk("t4b_lit", sum, 32'h99999999);
        do_ack();
`endif

        launch(32'h11111111, 32'h22222222, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", ready, 1'b1);
        chk("abort_valid", valid, 1'b0);
        chk("abort_sum", sum, 32'h0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            if (valid) saw = 1'b1;
        end
        chk("abort_novalid", saw, 1'b0);

        launch(32'h45454545, 32'h54545454, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a     = 32'h98765432;
        b     = 32'h11111111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_check("midstart", 32'h45454545, 32'h54545454, 1'b1, 1'b0, 2);
        do_ack();

        launch(32'h00000999, 32'h00000001, 1'b0, 1'b0, 1'b0);
        wait_check("b2b_a", 32'h00000999, 32'h00000001, 1'b0, 1'b0, 0);
        launch(32'h50000000, 32'h50000000, 1'b1, 1'b0, 1'b1);
        chk("b2b_vlow", valid, 1'b0);
        wait_check("b2b_b", 32'h50000000, 32'h50000000, 1'b1, 1'b0, 0);
        do_ack();

        s_a     = 4'd5;
        s_b     = 4'd7;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        chk("n1_vlow", s_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("n1_valid", s_valid, 1'b1);
        chk("n1_sum", s_sum, 4'd2);
        chk("n1_cout", s_cout, 1'b1);
        s_a     = 4'd3;
        s_b     = 4'd4;
        s_start = 1'b1;
        s_ack   = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_ack   = 1'b0;
        @(posedge clk);
        #1;
        chk("n1b_valid", s_valid, 1'b1);
        chk("n1b_sum", s_sum, 4'd7);
        chk("n1b_cout", s_cout, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = rnd_bcd(1'b1);
            rb = rnd_bcd(1'b1);
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            launch(ra, rb, rc, rs, 1'b0);
            wait_check("rand", ra, rb, rc, rs, 0);
            if ($urandom_range(1) == 0) do_ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
